// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit with eight selectable ops, a running AND accumulator,
// registered result flags and a two-entry (output register + skid) valid/ready buffer.
module bitwise_logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    output logic [WIDTH-1:0] acc_q
);

    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             o_zero;
    logic             o_ones;
    logic             o_parity;

    logic             s_valid;
    logic [WIDTH-1:0] s_data;
    logic             s_zero;
    logic             s_ones;
    logic             s_parity;

    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_eff;
    logic [WIDTH-1:0] result;
    logic             res_zero;
    logic             res_ones;
    logic             res_parity;
    logic             accept;
    logic             drain;

    assign accept = in_valid && in_ready;
    assign drain  = o_valid && out_ready;

    // A clear in the same cycle as an op 7 beat takes effect before the op sees the accumulator.
    always_comb begin
        acc_eff = acc_clr ? {WIDTH{1'b1}} : acc_reg;
        result  = '0;
        case (in_op)
            3'd0: result = in_a & in_b;
            3'd1: result = in_a | in_b;
            3'd2: result = in_a ^ in_b;
            3'd3: result = ~(in_a & in_b);
            3'd4: result = ~(in_a | in_b);
            3'd5: result = ~(in_a ^ in_b);
            3'd6: result = in_a & ~in_b;
            3'd7: result = acc_eff & in_a & in_b;
            default: result = '0;
        endcase
        res_zero   = ~|result;
        res_ones   = &result;
        res_parity = ^result;
    end

    // The skid entry only fills while the output register is stalled, so in_ready can be
    // derived purely from registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_zero   <= 1'b0;
            o_ones   <= 1'b0;
            o_parity <= 1'b0;
            s_valid  <= 1'b0;
            s_data   <= '0;
            s_zero   <= 1'b0;
            s_ones   <= 1'b0;
            s_parity <= 1'b0;
            acc_reg  <= {WIDTH{1'b1}};
        end else begin
            if (!o_valid || drain) begin
                if (s_valid) begin
                    o_valid  <= 1'b1;
                    o_data   <= s_data;
                    o_zero   <= s_zero;
                    o_ones   <= s_ones;
                    o_parity <= s_parity;
                    s_valid  <= 1'b0;
                end else if (accept) begin
                    o_valid  <= 1'b1;
                    o_data   <= result;
                    o_zero   <= res_zero;
                    o_ones   <= res_ones;
                    o_parity <= res_parity;
                end else begin
                    o_valid  <= 1'b0;
                end
            end else if (accept) begin
                s_valid  <= 1'b1;
                s_data   <= result;
                s_zero   <= res_zero;
                s_ones   <= res_ones;
                s_parity <= res_parity;
            end

            if (accept && in_op == 3'd7) begin
                acc_reg <= result;
            end else if (acc_clr) begin
                acc_reg <= {WIDTH{1'b1}};
            end
        end
    end

    assign in_ready   = !s_valid;
    assign out_valid  = o_valid;
    assign out_data   = o_data;
    assign out_zero   = o_zero;
    assign out_ones   = o_ones;
    assign out_parity = o_parity;
    assign acc_q      = acc_reg;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed scoreboard bench for bitwise_logic_unit at WIDTH=4: expected results are queued
// on input acceptance and compared when the output handshake fires.
module tb_bitwise_logic_unit;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_zero;
    logic         out_ones;
    logic         out_parity;
    logic [W-1:0] acc_q;

    logic [W-1:0] expQ[$];
    logic [W-1:0] pendingExp;
    int           checksTotal;
    int           checksPassed;

    bitwise_logic_unit #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_op(in_op),
        .acc_clr(acc_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_zero(out_zero),
        .out_ones(out_ones),
        .out_parity(out_parity),
        .acc_q(acc_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checksTotal++;
        assert (obs === expv) checksPassed++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic checkOutput(input logic [W-1:0] e);
        checkVal("out_data", out_data, e);
        checkVal("out_zero", out_zero, e == '0);
        checkVal("out_ones", out_ones, e == {W{1'b1}});
        checkVal("out_parity", out_parity, ^e);
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input logic clr, input logic [W-1:0] e);
        in_valid   = v;
        in_a       = a;
        in_b       = b;
        in_op      = op;
        acc_clr    = clr;
        pendingExp = e;
    endtask

    // Called at a negedge: scores the output handshake and queues an accepted beat, then
    // advances one clock.
    task automatic tick(output bit accepted);
        if (out_valid && out_ready) begin
            checksTotal++;
            assert (expQ.size() != 0) checksPassed++;
            else $error("[TB] FAIL spurious_output observed=%0h expected=none", out_data);
            if (expQ.size() != 0) checkOutput(expQ.pop_front());
        end
        accepted = in_valid && in_ready;
        if (accepted) expQ.push_back(pendingExp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sendBeat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                            input logic clr, input logic [W-1:0] e, output int cycles);
        bit acc;
        acc = 1'b0;
        cycles = 0;
        applyStimulus(1'b1, a, b, op, clr, e);
        while (!acc && cycles < 20) begin
            tick(acc);
            cycles++;
        end
        if (!acc) checkVal("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        in_valid = 1'b0;
        while ((out_valid || expQ.size() != 0) && n < 20) begin
            tick(acc);
            n++;
        end
        checkVal("drain_queue_empty", expQ.size(), 0);
        checkVal("drain_out_valid", out_valid, 0);
    endtask

    initial begin
        int cyc;
        int idx;
        int nAcc;
        bit acc;
        logic [W-1:0] bA[4];
        logic [W-1:0] bB[4];
        logic [2:0]   bOp[4];
        logic [W-1:0] bExp[4];
        logic [2:0]   opSeq;
        logic [W-1:0] seqExp[7];

        checksTotal  = 0;
        checksPassed = 0;
        rst_n        = 1'b0;
        out_ready    = 1'b1;
        applyStimulus(1'b0, '0, '0, 3'd0, 1'b0, '0);

        #12;
        checkVal("rst_out_valid", out_valid, 0);
        checkVal("rst_out_data", out_data, 0);
        checkVal("rst_flags", {out_zero, out_ones, out_parity}, 0);
        checkVal("rst_in_ready", in_ready, 1);
        checkVal("rst_acc_q", acc_q, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency 1 and flag behaviour.
        sendBeat(4'b1111, 4'b1111, 3'd0, 1'b0, 4'b1111, cyc);
        checkVal("lat_out_valid", out_valid, 1);
        checkVal("lat_out_data", out_data, 4'b1111);
        sendBeat(4'b0001, 4'b0101, 3'd0, 1'b0, 4'b0001, cyc);
        checkVal("b2b_cycles", cyc, 1);

        // All plain ops back to back.
        seqExp = '{4'b0001, 4'b0111, 4'b0110, 4'b1110, 4'b1000, 4'b1001, 4'b0010};
        for (int i = 0; i < 7; i++) begin
            opSeq = 3'(i);
            sendBeat(4'b0011, 4'b0101, opSeq, 1'b0, seqExp[i], cyc);
            checkVal($sformatf("op%0d_cycles", i), cyc, 1);
        end
        drain();

        // Accumulator chain.
        applyStimulus(1'b0, '0, '0, 3'd0, 1'b1, '0);
        tick(acc);
        acc_clr = 1'b0;
        sendBeat(4'b1110, 4'b1111, 3'd7, 1'b0, 4'b1110, cyc);
        sendBeat(4'b0111, 4'b1111, 3'd7, 1'b0, 4'b0110, cyc);
        checkVal("acc_chain", acc_q, 4'b0110);
        sendBeat(4'b1001, 4'b1001, 3'd7, 1'b0, 4'b0000, cyc);
        checkVal("acc_zero", acc_q, 4'b0000);
        drain();

        // Backpressure: only two beats fit while the output is stalled.
        bA   = '{4'b1100, 4'b1100, 4'b1100, 4'b1100};
        bB   = '{4'b1010, 4'b1010, 4'b1010, 4'b1010};
        bOp  = '{3'd0, 3'd1, 3'd2, 3'd3};
        bExp = '{4'b1000, 4'b1110, 4'b0110, 4'b0111};
        out_ready = 1'b0;
        idx  = 0;
        nAcc = 0;
        applyStimulus(1'b1, bA[0], bB[0], bOp[0], 1'b0, bExp[0]);
        for (cyc = 0; cyc < 5; cyc++) begin
            checkVal($sformatf("stall_in_ready%0d", cyc), in_ready, (cyc < 2) ? 1 : 0);
            if (cyc >= 1) checkVal($sformatf("stall_hold%0d", cyc), out_data, 4'b1000);
            tick(acc);
            if (acc) begin
                nAcc++;
                idx++;
                applyStimulus(1'b1, bA[idx], bB[idx], bOp[idx], 1'b0, bExp[idx]);
            end
        end
        checkVal("stall_accepts", nAcc, 2);
        out_ready = 1'b1;
        cyc = 0;
        while (idx < 4 && cyc < 20) begin
            tick(acc);
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 4) applyStimulus(1'b1, bA[idx], bB[idx], bOp[idx], 1'b0, bExp[idx]);
                else in_valid = 1'b0;
            end
        end
        checkVal("resume_accepts", idx, 4);
        drain();

        // Clear coinciding with op 7, then with a plain op.
        sendBeat(4'b0101, 4'b1111, 3'd7, 1'b1, 4'b0101, cyc);
        checkVal("clr_op7_acc", acc_q, 4'b0101);
        sendBeat(4'b0011, 4'b0101, 3'd1, 1'b1, 4'b0111, cyc);
        checkVal("clr_op1_acc", acc_q, 4'b1111);
        drain();

        // Reset with both entries full.
        out_ready = 1'b0;
        sendBeat(4'b0011, 4'b0011, 3'd7, 1'b0, 4'b0011, cyc);
        sendBeat(4'b0011, 4'b0011, 3'd7, 1'b0, 4'b0011, cyc);
        checkVal("full_in_ready", in_ready, 0);
        checkVal("full_acc", acc_q, 4'b0011);
        rst_n = 1'b0;
        #1;
        checkVal("mid_rst_out_valid", out_valid, 0);
        checkVal("mid_rst_in_ready", in_ready, 1);
        checkVal("mid_rst_acc", acc_q, 4'hF);
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(acc);
        checkVal("post_rst_idle", out_valid, 0);
        sendBeat(4'b1010, 4'b0110, 3'd2, 1'b0, 4'b1100, cyc);
        checkVal("post_rst_first", out_data, 4'b1100);
        drain();

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
